// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-entry scoreboard (pending) bits,
// optional hardwired-zero entry 0, optional write-to-read bypass and a
// sequential sweep-clear engine that zeroes one entry per cycle.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_valid_1,
  output logic              read_valid_2,
  input  logic              reg_write_enable,
  input  logic [ADDR_W-1:0] reg_write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_address,
  input  logic              clear_req,
  output logic              clear_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;

  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic [DATA_W:0]   w_rd1;
  logic [DATA_W:0]   w_rd2;

  // Qualify write/reserve: dropped while sweeping and for hardwired entry 0.
  always_comb begin
    w_wr_ok  = reg_write_enable && !r_busy &&
               !((ZERO_REG != 0) && (reg_write_address == '0));
    w_rsv_ok = reserve_enable && !r_busy &&
               !((ZERO_REG != 0) && (reserve_address == '0));
  end

  // Storage, scoreboard and sweep-clear FSM share one block so the sweep
  // and the write port never drive the same entry from two processes.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pending <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ok) begin
            r_mem[reg_write_address]     <= write_data;
            r_pending[reg_write_address] <= 1'b0;
          end
          // Placed after the write so a same-address reserve wins.
          if (w_rsv_ok) begin
            r_pending[reserve_address] <= 1'b1;
          end
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_mem[r_cnt[ADDR_W-1:0]]     <= '0;
          r_pending[r_cnt[ADDR_W-1:0]] <= 1'b0;
          if (r_cnt == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Read resolution, returned as {valid, data}.
  function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] res;
    if (r_busy) begin
      res = '0;
    end else if ((ZERO_REG != 0) && (a == '0)) begin
      res = {1'b1, {DATA_W{1'b0}}};
    end else if ((BYPASS != 0) && reg_write_enable && (reg_write_address == a)) begin
      res = {1'b1, write_data};
    end else begin
      res = {~r_pending[a], r_mem[a]};
    end
    return res;
  endfunction

  // Combinational read ports.
  always_comb begin
    w_rd1 = f_read(read_register_1);
    w_rd2 = f_read(read_register_2);
  end

  assign read_data_1  = w_rd1[DATA_W-1:0];
  assign read_valid_1 = w_rd1[DATA_W];
  assign read_data_2  = w_rd2[DATA_W-1:0];
  assign read_valid_2 = w_rd2[DATA_W];
  assign clear_busy   = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; a second instance without bypass
// shares all inputs to show the non-forwarded read value.
module tb_regfile_scoreboard;

  logic        clock;
  logic        Reset;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic [31:0] read_data_1, read_data_2;
  logic        read_valid_1, read_valid_2;
  logic [31:0] nb_data_1, nb_data_2;
  logic        nb_valid_1, nb_valid_2;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] write_data;
  logic        reserve_enable;
  logic [4:0]  reserve_address;
  logic        clear_req;
  logic        clear_busy, nb_busy;

  int n_checks = 0;
  int n_errors = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .Reset(Reset),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .read_valid_1(read_valid_1), .read_valid_2(read_valid_2),
    .reg_write_enable(reg_write_enable), .reg_write_address(reg_write_address),
    .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clock(clock), .Reset(Reset),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .read_data_1(nb_data_1), .read_data_2(nb_data_2),
    .read_valid_1(nb_valid_1), .read_valid_2(nb_valid_2),
    .reg_write_enable(reg_write_enable), .reg_write_address(reg_write_address),
    .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .clear_req(clear_req), .clear_busy(nb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_enable = 1'b0;
    reserve_enable   = 1'b0;
    clear_req        = 1'b0;
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      reg_write_enable  = 1'b1;
      reg_write_address = 5'(i);
      write_data        = 32'(i) * 32'h01010101;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1;
    read_register_1 = '0; read_register_2 = '0;
    reg_write_address = '0; write_data = '0; reserve_address = '0;
    idle_inputs();

    // Reset state
    #2;
    read_register_1 = 5'd13; read_register_2 = 5'd31;
    #1;
    check("rst_data1", 64'(read_data_1), 64'h0);
    check("rst_valid1", 64'(read_valid_1), 64'h1);
    check("rst_data2", 64'(read_data_2), 64'h0);
    check("rst_busy", 64'(clear_busy), 64'h0);
    step(); step();
    Reset = 1'b0;
    step();

    // Plain write then read
    reg_write_enable = 1'b1; reg_write_address = 5'd5; write_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    read_register_1 = 5'd5;
    #1;
    check("r5_data", 64'(read_data_1), 64'hDEADBEEF);
    check("r5_valid", 64'(read_valid_1), 64'h1);

    // Hardwired zero register
    reg_write_enable = 1'b1; reg_write_address = 5'd0; write_data = 32'h12345678;
    step();
    idle_inputs();
    read_register_1 = 5'd0; read_register_2 = 5'd0;
    #1;
    check("r0_data1", 64'(read_data_1), 64'h0);
    check("r0_data2", 64'(read_data_2), 64'h0);
    check("r0_valid1", 64'(read_valid_1), 64'h1);
    reserve_enable = 1'b1; reserve_address = 5'd0;
    step();
    idle_inputs();
    #1;
    check("r0_rsv_valid", 64'(read_valid_1), 64'h1);
    check("r0_rsv_valid2", 64'(read_valid_2), 64'h1);

    // Bypass vs no bypass, before the edge
    read_register_2 = 5'd7;
    reg_write_enable = 1'b1; reg_write_address = 5'd7; write_data = 32'hA5A5A5A5;
    #1;
    check("byp_data2", 64'(read_data_2), 64'hA5A5A5A5);
    check("byp_valid2", 64'(read_valid_2), 64'h1);
    check("nobyp_data2", 64'(nb_data_2), 64'h0);
    step();
    idle_inputs();
    #1;
    check("r7_after", 64'(nb_data_2), 64'hA5A5A5A5);

    // Scoreboard sequence on r9
    reserve_enable = 1'b1; reserve_address = 5'd9;
    step();
    idle_inputs();
    read_register_1 = 5'd9;
    #1;
    check("r9_pending", 64'(read_valid_1), 64'h0);
    check("r9_pend_nb", 64'(nb_valid_1), 64'h0);
    reg_write_enable = 1'b1; reg_write_address = 5'd9; write_data = 32'h55;
    #1;
    check("r9_byp_valid", 64'(read_valid_1), 64'h1);
    step();
    idle_inputs();
    #1;
    check("r9_data55", 64'(read_data_1), 64'h55);
    check("r9_valid55", 64'(read_valid_1), 64'h1);
    reg_write_enable = 1'b1; reg_write_address = 5'd9; write_data = 32'h66;
    reserve_enable = 1'b1; reserve_address = 5'd9;
    step();
    idle_inputs();
    #1;
    check("r9_data66", 64'(read_data_1), 64'h66);
    check("r9_valid66", 64'(read_valid_1), 64'h0);

    // Write and reserve to different addresses
    reg_write_enable = 1'b1; reg_write_address = 5'd10; write_data = 32'h1010;
    reserve_enable = 1'b1; reserve_address = 5'd11;
    step();
    idle_inputs();
    read_register_1 = 5'd10; read_register_2 = 5'd11;
    #1;
    check("r10_data", 64'(read_data_1), 64'h1010);
    check("r10_valid", 64'(read_valid_1), 64'h1);
    check("r11_valid", 64'(read_valid_2), 64'h0);

    // Sweep clear with dropped write/reserve and an ignored re-request
    fill();
    reserve_enable = 1'b1; reserve_address = 5'd3;
    step();
    idle_inputs();
    read_register_1 = 5'd20;
    #1;
    check("pre_clr_r20", 64'(read_data_1), 64'(32'd20 * 32'h01010101));
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clr_busy_start", 64'(clear_busy), 64'h1);
    check("clr_read_data", 64'(read_data_1), 64'h0);
    check("clr_read_valid", 64'(read_valid_1), 64'h0);
    n = 0;
    while (clear_busy && n < 100) begin
      n++;
      if (n == 20) begin
        reg_write_enable = 1'b1; reg_write_address = 5'd2; write_data = 32'hCAFE;
      end
      if (n == 21) begin
        reserve_enable = 1'b1; reserve_address = 5'd6;
      end
      if (n == 25) clear_req = 1'b1;
      step();
      idle_inputs();
    end
    check("clr_cycles", 64'(n), 64'd32);
    for (int a = 0; a < 32; a++) begin
      read_register_1 = 5'(a); read_register_2 = 5'(a);
      #1;
      check($sformatf("clr_data_r%0d", a), 64'(read_data_1), 64'h0);
      check($sformatf("clr_valid_r%0d", a), 64'({read_valid_1, read_valid_2}), 64'h3);
    end
    step();
    check("clr_no_restart", 64'(clear_busy), 64'h0);

    // Reset asserted mid-sweep
    fill();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 9; c++) step();
    read_register_1 = 5'd31; read_register_2 = 5'd30;
    #1;
    check("mid_r31_busy_read", 64'(read_valid_1), 64'h0);
    Reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(clear_busy), 64'h0);
    check("mid_rst_r31", 64'(read_data_1), 64'h0);
    check("mid_rst_r30", 64'(read_data_2), 64'h0);
    check("mid_rst_valid", 64'({read_valid_1, read_valid_2}), 64'h3);
    step();
    Reset = 1'b0;
    step();
    read_register_1 = 5'd25;
    #1;
    check("post_rst_busy", 64'(clear_busy), 64'h0);
    check("post_rst_r25", 64'(read_data_1), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-register file for the pipelined CPU generation: configurable data width and depth.
- Two combinational read ports and one synchronous write port.
- Optional hardwired-zero register 0.
- Optional write-to-read bypass.
- Per-register pending (scoreboard) bits with valid flags on each read port.
- Sequential sweep-clear engine that zeroes the file one entry per cycle without a global reset.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 reads as 0, is never written and is never pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clock  input  1  sole clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- read_register_1  input  ADDR_W  read port 1 address (rs).
- read_register_2  input  ADDR_W  read port 2 address (rt).
- read_data_1  output  DATA_W  read port 1 data.
- read_data_2  output  DATA_W  read port 2 data.
- read_valid_1  output  1  port 1 data is architecturally current (not pending).
- read_valid_2  output  1  port 2 data is architecturally current.
- reg_write_enable  input  1  write strobe.
- reg_write_address  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- reserve_enable  input  1  mark a register pending (producer issued).
- reserve_address  input  ADDR_W  register to mark pending.
- clear_req  input  1  start a sweep clear.
- clear_busy  output  1  sweep clear in progress.

Behaviour:
- Reset: one clock, named clock; reset named Reset, asynchronous and active-high. While Reset is high:
  - all entries are 0 and all pending bits are 0;
  - the FSM is IDLE, the sweep counter is 0 and clear_busy is 0;
  - read_data_x shows the (zero) contents and read_valid_x is 1.
- Write, at posedge clock: the entry is written when reg_write_enable=1, clear_busy=0, and not (ZERO_REG=1 and reg_write_address=0).
  - The entry takes write_data.
  - Its pending bit clears.
- Reserve, at posedge clock: when reserve_enable=1, clear_busy=0, and not (ZERO_REG=1 and reserve_address=0), the pending bit of reserve_address is set.
- Write and reserve to the same address in the same cycle: the data is stored and pending ends set (the new producer wins).
- Write and reserve to different addresses: both take effect independently.
- Reads are combinational, zero-cycle latency. Priority per port:
  1. clear_busy=1: data 0, valid 0.
  2. ZERO_REG=1 and address=0: data 0, valid 1.
  3. BYPASS=1, reg_write_enable=1 and reg_write_address equals the read address: data = write_data, valid 1. Bypass is suppressed for the cases 1 and 2 cover.
  4. Otherwise: data = stored entry, valid = not pending.
- Both ports may read the same address; each resolves independently.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE to CLEAR when clear_req=1 at a rising edge; the counter loads 0.
  - In CLEAR, each rising edge zeroes the entry at the counter, clears its pending bit and increments the counter.
  - After entry DEPTH-1 is cleared the FSM returns to IDLE.
  - clear_busy is high exactly in CLEAR, i.e. DEPTH cycles: request sampled at edge k; entries cleared at edges k+1..k+DEPTH; clear_busy low after edge k+DEPTH.
  - clear_req in CLEAR is ignored (no restart, no extension).
  - Writes and reserves presented while clear_busy=1 are dropped, not queued.
  - A write presented in the same cycle clear_req is sampled in IDLE is performed; the sweep then overwrites it with 0.
- Reset asserted mid-clear: the FSM returns to IDLE immediately and all entries are 0.
- Address wrap: the counter is ADDR_W+1 bits or compares to DEPTH-1; it never wraps silently into a second pass.
- No X ever appears on outputs after reset, for any address.

Test Plan:
- Reset, then write 0xDEADBEEF to r5, read port 1 = 5 in the following cycle -> read_data_1 = 0xDEADBEEF, read_valid_1 = 1.
- ZERO_REG=1: write 0x12345678 to r0, read both ports at 0 -> data 0, valid 1. Reserve r0 -> still valid 1.
- BYPASS=1: write 0xA5A5A5A5 to r7 while read_register_2 = 7 in the same cycle -> read_data_2 = 0xA5A5A5A5 before the edge. With BYPASS=0 -> old value (0).
- Reserve r9, next cycle read r9 -> valid 0.
- Scoreboard sequence:
  - write r9 = 0x55 -> valid 1, data 0x55;
  - same-cycle reserve and write of r9 = 0x66 -> data 0x66, valid 0.
- Sweep clear:
  - fill r1..r31 with nonzero values, pulse clear_req -> clear_busy high exactly 32 cycles (DEPTH=32);
  - writes issued during busy are dropped;
  - afterwards every register reads 0 with valid 1.
  - Repeat with Reset asserted at cycle 10 of the sweep -> immediate IDLE, all zero.
